stopwatch_core: RTL and testbench

Consumer of the single-cycle tick enables produced by the clock divider. Keeps an mm:ss stopwatch value in BCD, runs on the 1 Hz tick, supports pause/resume and a per-field adjust mode stepped by the 2 Hz tick. Provides blink-blank flags for the selected field in adjust mode, driven by the 4 Hz tick. Sits between the divider/button conditioning and the seven-segment display mux.

---
 rtl/stopwatch_core_pkg.sv | 14 +
 rtl/stopwatch_core_bcd_mod_counter.sv | 56 +++++
 rtl/stopwatch_core.sv | 99 +++++++++
 tb/tb_stopwatch_core.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_core_pkg.sv
// Shared constants and state encoding for the mm:ss stopwatch core.
package stopwatch_core_pkg;

    localparam int BCD_W = 4;

    localparam logic SEL_MIN = 1'b0;
    localparam logic SEL_SEC = 1'b1;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } state_t;

endpackage

// File: rtl/stopwatch_core_bcd_mod_counter.sv
// Two-digit BCD counter that wraps from MAX back to 00; carry_out flags the wrap step.
module bcd_mod_counter
    import stopwatch_core_pkg::*;
#(
    parameter int MAX = 59
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             inc,
    output logic             carry_out,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones
);

    localparam logic [BCD_W-1:0] MAX_TENS = BCD_W'(MAX / 10);
    localparam logic [BCD_W-1:0] MAX_ONES = BCD_W'(MAX % 10);
    localparam logic [BCD_W-1:0] DIGIT_ONE  = BCD_W'(1);
    localparam logic [BCD_W-1:0] DIGIT_NINE = BCD_W'(9);

    logic [BCD_W-1:0] tens_q, tens_d;
    logic [BCD_W-1:0] ones_q, ones_d;
    logic             at_max;

    assign at_max    = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);
    assign carry_out = inc & at_max;

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (inc) begin
            if (at_max) begin
                tens_d = '0;
                ones_d = '0;
            end else if (ones_q == DIGIT_NINE) begin
                ones_d = '0;
                tens_d = tens_q + DIGIT_ONE;
            end else begin
                ones_d = ones_q + DIGIT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            tens_q <= '0;
            ones_q <= '0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign tens = tens_q;
    assign ones = ones_q;

endmodule

// File: rtl/stopwatch_core.sv
// mm:ss BCD stopwatch: run/pause FSM, per-field adjust on the 2 Hz tick, 2 Hz blink flags.
module stopwatch_core
    import stopwatch_core_pkg::*;
#(
    parameter int MAX_MIN = 59
) (
    input  logic             clk_100mhz,
    input  logic             rst,
    input  logic             tick_1hz,
    input  logic             tick_2hz,
    input  logic             tick_4hz,
    input  logic             pause_pulse,
    input  logic             adj,
    input  logic             sel,
    output logic [BCD_W-1:0] min_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic             blank_min,
    output logic             blank_sec,
    output logic             running
);

    state_t state_q, state_d;
    logic   phase_q, phase_d;
    logic   blank_min_q, blank_min_d;
    logic   blank_sec_q, blank_sec_d;

    logic count_en;
    logic adj_step;
    logic sec_inc, sec_carry;
    logic min_inc, min_carry_unused;

    // Counting uses the pre-toggle state, so a pause on a tick cycle still counts once.
    assign count_en = tick_1hz & ~adj & (state_q == ST_RUN);
    assign adj_step = tick_2hz & adj;

    assign sec_inc = count_en | (adj_step & (sel == SEL_SEC));
    assign min_inc = (count_en & sec_carry) | (adj_step & (sel == SEL_MIN));

    bcd_mod_counter #(
        .MAX (59)
    ) u_sec (
        .clk       (clk_100mhz),
        .srst      (rst),
        .inc       (sec_inc),
        .carry_out (sec_carry),
        .tens      (sec_tens),
        .ones      (sec_ones)
    );

    bcd_mod_counter #(
        .MAX (MAX_MIN)
    ) u_min (
        .clk       (clk_100mhz),
        .srst      (rst),
        .inc       (min_inc),
        .carry_out (min_carry_unused),
        .tens      (min_tens),
        .ones      (min_ones)
    );

    always_comb begin
        state_d     = state_q;
        phase_d     = 1'b0;
        blank_min_d = 1'b0;
        blank_sec_d = 1'b0;

        if (pause_pulse) begin
            state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
        end

        if (adj) begin
            phase_d = tick_4hz ? ~phase_q : phase_q;
        end

        blank_min_d = adj & (sel == SEL_MIN) & phase_d;
        blank_sec_d = adj & (sel == SEL_SEC) & phase_d;
    end

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            state_q     <= ST_RUN;
            phase_q     <= 1'b0;
            blank_min_q <= 1'b0;
            blank_sec_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            blank_min_q <= blank_min_d;
            blank_sec_q <= blank_sec_d;
        end
    end

    assign running   = (state_q == ST_RUN);
    assign blank_min = blank_min_q;
    assign blank_sec = blank_sec_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed scoreboard bench for stopwatch_core: stimulus pushes expected outputs, monitor pops and compares.
module tb_stopwatch_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1hz, tick_2hz, tick_4hz, pause_pulse;
    logic       adj, sel;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       blank_min, blank_sec, running;

    always #5 clk = ~clk;

    stopwatch_core #(
        .MAX_MIN (59)
    ) dut (
        .clk_100mhz  (clk),
        .rst         (rst),
        .tick_1hz    (tick_1hz),
        .tick_2hz    (tick_2hz),
        .tick_4hz    (tick_4hz),
        .pause_pulse (pause_pulse),
        .adj         (adj),
        .sel         (sel),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .blank_min   (blank_min),
        .blank_sec   (blank_sec),
        .running     (running)
    );

    typedef struct {
        string       name;
        logic [18:0] vec;   // {mm, ss, blank_min, blank_sec, running}
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    int          checks = 0;
    int          errors = 0;
    logic [18:0] act;

    assign act = {min_tens, min_ones, sec_tens, sec_ones, blank_min, blank_sec, running};

    task automatic push_exp(input string name, input logic [7:0] mm, input logic [7:0] ss,
                            input logic run, input logic bm, input logic bs);
        exp_t e;
        e.name = name;
        e.vec  = {mm, ss, bm, bs, run};
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs just after a rising edge; pulses drop after the next edge.
    task automatic cyc(input logic t1, input logic t2, input logic t4, input logic pp);
        tick_1hz    = t1;
        tick_2hz    = t2;
        tick_4hz    = t4;
        pause_pulse = pp;
        @(posedge clk);
        #1;
        tick_1hz    = 1'b0;
        tick_2hz    = 1'b0;
        tick_4hz    = 1'b0;
        pause_pulse = 1'b0;
    endtask

    task automatic tick(input logic t1, input logic t2, input logic t4, input logic pp);
        cyc(t1, t2, t4, pp);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            checks++;
            if (act !== cur.vec) begin
                errors++;
                $display("FAIL %s: got %h%h:%h%h bm=%b bs=%b run=%b, expected %h:%h bm=%b bs=%b run=%b",
                         cur.name, min_tens, min_ones, sec_tens, sec_ones, blank_min, blank_sec, running,
                         cur.vec[18:11], cur.vec[10:3], cur.vec[2], cur.vec[1], cur.vec[0]);
            end else begin
                $display("[%0t] %s: %h%h:%h%h bm=%b bs=%b run=%b ok", $time, cur.name,
                         min_tens, min_ones, sec_tens, sec_ones, blank_min, blank_sec, running);
            end
            checks++;
            if (min_tens > 4'd9 || min_ones > 4'd9 || sec_tens > 4'd9 || sec_ones > 4'd9) begin
                errors++;
                $display("FAIL %s_digit_range: got %h%h:%h%h, expected every digit <= 9",
                         cur.name, min_tens, min_ones, sec_tens, sec_ones);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout at %0t, expected run to complete", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; adj = 1'b0; sel = 1'b0;
        tick_1hz = 1'b0; tick_2hz = 1'b0; tick_4hz = 1'b0; pause_pulse = 1'b0;
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        push_exp("reset", 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Plain counting: first step lands one cycle after the tick, then 61 total.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        push_exp("first_count", 8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (60) tick(1'b1, 1'b0, 1'b0, 1'b0);
        push_exp("count_61", 8'h01, 8'h01, 1'b1, 1'b0, 1'b0);

        // Preload 59:58 via adjust, then roll over through 59:59 to 00:00.
        adj = 1'b1; sel = 1'b0;
        repeat (58) tick(1'b0, 1'b1, 1'b0, 1'b0);
        sel = 1'b1;
        repeat (57) tick(1'b0, 1'b1, 1'b0, 1'b0);
        push_exp("preload", 8'h59, 8'h58, 1'b1, 1'b0, 1'b0);
        adj = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        push_exp("to_5959", 8'h59, 8'h59, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        push_exp("wrap_0000", 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Pause coinciding with a count tick.
        repeat (5) tick(1'b1, 1'b0, 1'b0, 1'b0);
        push_exp("at_0005", 8'h00, 8'h05, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        push_exp("pause_with_tick", 8'h00, 8'h06, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0);
        push_exp("paused_hold", 8'h00, 8'h06, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        push_exp("resume", 8'h00, 8'h06, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        push_exp("resumed_count", 8'h00, 8'h07, 1'b1, 1'b0, 1'b0);

        // Adjust seconds across the wrap, then minutes; 1 Hz ticks must not count.
        adj = 1'b1; sel = 1'b1;
        repeat (51) tick(1'b0, 1'b1, 1'b0, 1'b0);
        push_exp("adj_sec_58", 8'h00, 8'h58, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        push_exp("adj_sec_59", 8'h00, 8'h59, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        push_exp("adj_sec_wrap_no_carry", 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        push_exp("adj_sec_01", 8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
        sel = 1'b0;
        repeat (2) tick(1'b0, 1'b1, 1'b0, 1'b0);
        push_exp("adj_min_02", 8'h02, 8'h01, 1'b1, 1'b0, 1'b0);
        repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0);
        push_exp("adj_ignores_1hz", 8'h02, 8'h01, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        push_exp("adj_2hz_with_1hz", 8'h03, 8'h01, 1'b1, 1'b0, 1'b0);

        // Blink phase on the minutes field, then seconds, then clearing by leaving adjust.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
            push_exp($sformatf("blink_min_%0d", i), 8'h03, 8'h01, 1'b1, (i % 2 == 0), 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
        end
        sel = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        push_exp("blink_sec", 8'h03, 8'h01, 1'b1, 1'b0, 1'b1);
        adj = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        push_exp("blank_clear", 8'h03, 8'h01, 1'b1, 1'b0, 1'b0);
        adj = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        push_exp("phase_cleared", 8'h03, 8'h01, 1'b1, 1'b0, 1'b0);

        // Paused + adjust to 12:34, then reset together with every pulse.
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        push_exp("pause_in_adj", 8'h03, 8'h01, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        sel = 1'b0;
        repeat (9) tick(1'b0, 1'b1, 1'b0, 1'b0);
        sel = 1'b1;
        repeat (33) tick(1'b0, 1'b1, 1'b0, 1'b0);
        push_exp("paused_1234", 8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        push_exp("paused_blink", 8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        push_exp("reset_mid_adjust", 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        rst = 1'b0; adj = 1'b0; sel = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        push_exp("count_after_reset", 8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
